mul_err_eval: RTL and testbench

- Sequential error evaluator that sits on the output side of a combinational approximate multiplier.
- On start it sweeps every input vector of the multiplier and reads back the multiplier's outputs each cycle. It compares each readback with the exact product.
- Reports maximum absolute error, worst-case vector, error count, error sum and an error-threshold violation flag.
- Used in the approximate-circuit flow to confirm on silicon or in simulation that a generated netlist meets its ET bound.

---
 rtl/mul_err_eval.sv | 126 ++++++++++++
 tb/tb_mul_err_eval.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_err_eval.sv
// Exhaustive error evaluator for a combinational approximate multiplier: sweeps
// every input vector, compares each readback with the exact product, keeps stats.
module mul_err_eval #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IN_W-1:0]       vec_out,
  input  logic [OUT_W-1:0]      approx_in,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W-1:0]       worst_vec,
  output logic [IN_W:0]         err_count,
  output logic [OUT_W+IN_W-1:0] err_sum,
  output logic                  viol,
  output logic [1:0]            state_o
);

  // Handshake: start is a level sampled on the rising edge and only honoured in
  // IDLE; done pulses for one cycle and results stay valid until the next start.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int HW = IN_W / 2;
  localparam logic [OUT_W-1:0] ET_W = OUT_W'(ET);

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         vec_q, vec_d;
  logic [OUT_W-1:0]        max_q, max_d;
  logic [IN_W-1:0]         worst_q, worst_d;
  logic [IN_W:0]           cnt_q, cnt_d;
  logic [OUT_W+IN_W-1:0]   sum_q, sum_d;
  logic                    viol_q, viol_d;

  logic [HW-1:0]           op_a, op_b;
  logic [IN_W-1:0]         prod;
  logic [OUT_W-1:0]        exact;
  logic signed [OUT_W:0]   diff;
  logic [OUT_W-1:0]        err;

  // One extra sign bit lets the difference go negative before taking magnitude.
  always_comb begin
    op_a  = vec_q[HW-1:0];
    op_b  = vec_q[IN_W-1:HW];
    prod  = IN_W'(op_a) * IN_W'(op_b);
    exact = OUT_W'(prod);
    diff  = $signed({1'b0, exact}) - $signed({1'b0, approx_in});
    err   = diff[OUT_W] ? OUT_W'(-diff) : diff[OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    max_d   = max_q;
    worst_d = worst_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    viol_d  = viol_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          vec_d   = '0;
          max_d   = '0;
          worst_d = '0;
          cnt_d   = '0;
          sum_d   = '0;
          viol_d  = 1'b0;
        end
      end
      SWEEP: begin
        // Strict compare keeps the earliest vector on ties.
        if (err > max_q) begin
          max_d   = err;
          worst_d = vec_q;
        end
        if (err != '0) cnt_d = cnt_q + (IN_W+1)'(1);
        sum_d = sum_q + (OUT_W+IN_W)'(err);
        if (err > ET_W) viol_d = 1'b1;
        if (&vec_q) state_d = DONE;
        else        vec_d   = vec_q + IN_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      max_q   <= '0;
      worst_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      max_q   <= max_d;
      worst_q <= worst_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      viol_q  <= viol_d;
    end
  end

  assign busy      = (state_q == SWEEP) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign vec_out   = vec_q;
  assign max_err   = max_q;
  assign worst_vec = worst_q;
  assign err_count = cnt_q;
  assign err_sum   = sum_q;
  assign viol      = viol_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mul_err_eval.sv
// Bench for mul_err_eval: a behavioural multiplier with selectable fault modes
// feeds approx_in; expected sweep results are queued at start and checked at done.
module tb_mul_err_eval;

  localparam int IN_W  = 4;
  localparam int OUT_W = 4;
  localparam int ET    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [IN_W-1:0]       vec_out;
  logic [OUT_W-1:0]      approx_in;
  logic [OUT_W-1:0]      max_err;
  logic [IN_W-1:0]       worst_vec;
  logic [IN_W:0]         err_count;
  logic [OUT_W+IN_W-1:0] err_sum;
  logic                  viol;
  logic [1:0]            state_o;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] wv;
    logic [4:0] cnt;
    logic [7:0] sum;
    logic       viol;
  } res_t;

  typedef struct {
    int   mode;
    res_t exp;
  } vec_t;

  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int mode_r   = 0;
  int cyc_g    = 0;

  mul_err_eval #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .vec_out(vec_out), .approx_in(approx_in), .max_err(max_err),
    .worst_vec(worst_vec), .err_count(err_count), .err_sum(err_sum),
    .viol(viol), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Multiplier under test: 0 exact, 1 stuck-at-0, 2 err 5 at F, 3 err 6 at F,
  // 4 err 2 at vectors 5 and A, 5 LSB flipped everywhere.
  function automatic logic [3:0] approx_fn(input int m, input logic [3:0] v);
    logic [3:0] ex;
    ex = {2'b00, v[1:0]} * {2'b00, v[3:2]};
    case (m)
      1:       return 4'd0;
      2:       return (v == 4'hF) ? 4'd4 : ex;
      3:       return (v == 4'hF) ? 4'd3 : ex;
      4:       return (v == 4'h5) ? ex + 4'd2 : (v == 4'hA) ? ex - 4'd2 : ex;
      5:       return ex ^ 4'b0001;
      default: return ex;
    endcase
  endfunction

  always_comb approx_in = approx_fn(mode_r, vec_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_vec"}, vec_out, 0);
    check({tag, "_max"}, max_err, 0);
    check({tag, "_worst"}, worst_vec, 0);
    check({tag, "_cnt"}, err_count, 0);
    check({tag, "_sum"}, err_sum, 0);
    check({tag, "_viol"}, viol, 0);
  endtask

  // Start a sweep, optionally pulse start at relative cycles s1/s2, wait for done.
  task automatic do_sweep(input int mode, input res_t exp, input int s1, input int s2,
                          input bit gap, output int t_start, output int t_done);
    int   cyc;
    bit   seen;
    res_t got;
    if (gap) repeat ($urandom_range(0, 3)) @(posedge clk);
    mode_r = mode;
    @(posedge clk);
    #1 start = 1'b1;
    t_start = cyc_g;
    exp_q.push_back(exp);
    cyc  = 0;
    seen = 1'b0;
    t_done = -1;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
      start = (cyc == s1) || (cyc == s2);
      @(negedge clk);
      if (cyc <= 17) check("busy", busy, 1);
      if (done) begin
        seen   = 1'b1;
        t_done = cyc_g;
        check("done_cycle", cyc, 17);
        got = res_t'(exp_q.pop_front());
        check("max_err", max_err, got.mx);
        check("worst_vec", worst_vec, got.wv);
        check("err_count", err_count, got.cnt);
        check("err_sum", err_sum, got.sum);
        check("viol", viol, got.viol);
        check("vec_hold", vec_out, 4'hF);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   ts, td, ts2, td2;

    tbl[0] = '{0, '{4'd0, 4'h0, 5'd0,  8'd0,  1'b0}};
    tbl[1] = '{1, '{4'd9, 4'hF, 5'd9,  8'd36, 1'b1}};
    tbl[2] = '{2, '{4'd5, 4'hF, 5'd1,  8'd5,  1'b0}};
    tbl[3] = '{3, '{4'd6, 4'hF, 5'd1,  8'd6,  1'b1}};
    tbl[4] = '{4, '{4'd2, 4'h5, 5'd2,  8'd4,  1'b0}};
    tbl[5] = '{5, '{4'd1, 4'h0, 5'd16, 8'd16, 1'b0}};

    rst_n = 1'b0;
    start = 1'b0;
    #12;
    check_idle_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_sweep(tbl[i].mode, tbl[i].exp, 0, 0, 1'b1, ts, td);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_busy", busy, 0);
    check("hold_state", state_o, 0);
    check("hold_max", max_err, 1);
    check("hold_cnt", err_count, 16);

    // start pulses in cycles 5 and 17 must not disturb the sweep.
    do_sweep(1, tbl[1].exp, 5, 17, 1'b1, ts, td);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 0);
    check("ign_done", done, 0);
    check("ign_state", state_o, 0);

    // Back-to-back: second start in cycle 18, its done in cycle 35.
    do_sweep(0, tbl[0].exp, 0, 0, 1'b0, ts, td);
    do_sweep(4, tbl[4].exp, 0, 0, 1'b0, ts2, td2);
    check("b2b_start", ts2 - ts, 18);
    check("b2b_done", td2 - ts, 35);

    // Reset in the middle of a stuck-at-0 sweep.
    mode_r = 1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("pre_rst_busy", busy, 1);
    check("pre_rst_nonzero", (err_count != 0), 1);
    rst_n = 1'b0;
    #1 check_idle_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_sweep(0, tbl[0].exp, 0, 0, 1'b1, ts, td);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
